// File: rtl/heatmap_pkg.sv
// Shared constants, FSM encoding and RGB332 palette for the heat-map row pipeline.
package heatmap_pkg;

  localparam int unsigned NODES    = 64;
  localparam int unsigned CELL_W   = 4;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCapture = 3'd1,
    StSettle  = 3'd2,
    StDrain   = 3'd3,
    StAdvance = 3'd4
  } state_e;

  // RGB332 palette: rrr_ggg_bb
  localparam logic [7:0] RED      = 8'hE0;
  localparam logic [7:0] ORANGE   = 8'hF4;
  localparam logic [7:0] MARIGOLD = 8'hF8;
  localparam logic [7:0] WHITE    = 8'hFF;
  localparam logic [7:0] CYAN     = 8'h1F;
  localparam logic [7:0] PINK     = 8'hEE;
  localparam logic [7:0] PURPLE   = 8'h82;
  localparam logic [7:0] BLACK    = 8'h00;

  // Row pointer step with wrap at the bottom of the screen.
  function automatic logic [9:0] next_row(input logic [9:0] y, input int unsigned height);
    return (32'(y) == height - 1) ? 10'd0 : y + 10'd1;
  endfunction

endpackage

// File: rtl/row_buffer.sv
// Single-row colour store: one write port, one read port with 1-cycle registered latency.
module row_buffer #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_50,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage needs no reset: the owner gates every read with its own valid bits.
  always_ff @(posedge clk_50) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/grid_row_receiver.sv
// Captures one row of node colours from the grid producer, then streams it to the
// frame-buffer writer as CELL_W-wide pixel runs on the current screen row.
module grid_row_receiver #(
  parameter int unsigned NODES    = heatmap_pkg::NODES,
  parameter int unsigned CELL_W   = heatmap_pkg::CELL_W,
  parameter int unsigned SCREEN_H = heatmap_pkg::SCREEN_H
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        enable,
  output logic        write_sig,
  input  logic [31:0] write_data,
  input  logic [7:0]  write_addr,
  input  logic        done_write_sig,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_color,
  input  logic        pix_ready,
  output logic        row_done,
  output logic        busy
);
  import heatmap_pkg::*;

  localparam int unsigned ADDR_W = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int unsigned SUB_W  = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_NODE = ADDR_W'(NODES - 1);
  localparam logic [SUB_W-1:0]  LAST_SUB  = SUB_W'(CELL_W - 1);

  state_e            state_q, state_d;
  logic              done_q;
  logic              last_q, last_d;
  logic [NODES-1:0]  valid_q;
  logic [ADDR_W-1:0] node_q, node_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [9:0]        y_q, y_d;

  logic              addr_ok, wr_en, done_rise, last_hit, accept, drain_end;
  logic [7:0]        rd_data;
  logic              unused_data;

  // Only the RGB332 byte of the producer word is meaningful.
  assign unused_data = ^write_data[31:8];

  assign addr_ok   = 32'(write_addr) < NODES;
  assign wr_en     = (state_q == StCapture) && addr_ok;
  assign done_rise = done_write_sig && !done_q;
  assign last_hit  = wr_en && (32'(write_addr) == NODES - 1);
  assign accept    = (state_q == StDrain) && pix_ready;
  assign drain_end = accept && (node_q == LAST_NODE) && (sub_q == LAST_SUB);

  // Next-state: capture ends on a done edge or on the last address seen twice in a row.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable) state_d = StCapture;
      StCapture: if (done_rise || (last_hit && last_q)) state_d = StSettle;
      StSettle:  state_d = StDrain;
      StDrain:   if (drain_end) state_d = StAdvance;
      StAdvance: state_d = enable ? StCapture : StIdle;
      default:   state_d = StIdle;
    endcase
    last_d = last_hit && (state_d == StCapture);
  end

  // Drain walk: sub-column fastest, advancing only on an accepted pixel.
  always_comb begin
    node_d = node_q;
    sub_d  = sub_q;
    if (state_q != StDrain) begin
      node_d = '0;
      sub_d  = '0;
    end else if (accept) begin
      if (sub_q == LAST_SUB) begin
        sub_d  = '0;
        node_d = node_q + ADDR_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
    y_d = (state_q == StAdvance) ? next_row(y_q, SCREEN_H) : y_q;
  end

  // Control and position state.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      node_q  <= '0;
      sub_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_write_sig;
      last_q  <= last_d;
      node_q  <= node_d;
      sub_q   <= sub_d;
      y_q     <= y_d;
    end
  end

  // Valid bits mark which nodes the producer actually delivered this row.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (state_q == StAdvance) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[write_addr[ADDR_W-1:0]] <= 1'b1;
    end
  end

  // Read address is the node shown next cycle, so SETTLE prefetches node 0.
  row_buffer #(
    .DEPTH  (NODES),
    .WIDTH  (8),
    .ADDR_W (ADDR_W)
  ) u_row_buffer (
    .clk_50  (clk_50),
    .we      (wr_en),
    .wr_addr (write_addr[ADDR_W-1:0]),
    .wr_data (write_data[7:0]),
    .rd_addr (node_d),
    .rd_data (rd_data)
  );

  // Outputs decode straight from state so reset silences them immediately.
  always_comb begin
    write_sig = (state_q == StCapture);
    busy      = (state_q != StIdle);
    row_done  = (state_q == StAdvance);
    pix_we    = (state_q == StDrain);
    pix_y     = y_q;
    pix_x     = '0;
    pix_color = 8'h00;
    if (pix_we) begin
      pix_x     = 10'(node_q) * 10'(CELL_W) + 10'(sub_q);
      pix_color = valid_q[node_q] ? rd_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_grid_row_receiver.sv
// Self-checking bench: producer model, pixel scoreboard and a small second instance for Y wrap.
module tb_grid_row_receiver;

  logic        clk_50 = 1'b0;
  logic        reset, enable, done_write_sig, pix_ready;
  logic [31:0] write_data;
  logic [7:0]  write_addr;
  logic        write_sig, pix_we, row_done, busy;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_color;

  always #10 clk_50 = ~clk_50;

  grid_row_receiver dut (
    .clk_50(clk_50), .reset(reset), .enable(enable), .write_sig(write_sig),
    .write_data(write_data), .write_addr(write_addr), .done_write_sig(done_write_sig),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_ready(pix_ready), .row_done(row_done), .busy(busy)
  );

  // Small instance: short rows make 481 consecutive rows cheap.
  logic        reset_s, done_s, s_go, s_done;
  logic        enable_s, pix_ready_s;
  logic [7:0]  write_addr_s;
  logic [31:0] write_data_s;
  logic        write_sig_s, pix_we_s, row_done_s_unused, busy_s_unused;
  logic [9:0]  pix_x_s, pix_y_s;
  logic [7:0]  pix_color_s_unused;
  int          rows_s = 0;

  assign enable_s     = s_go && !s_done;
  assign pix_ready_s  = 1'b1;
  assign write_addr_s = 8'hFF;
  assign write_data_s = 32'h0;

  grid_row_receiver #(.NODES(4), .CELL_W(2), .SCREEN_H(480)) dut_s (
    .clk_50(clk_50), .reset(reset_s), .enable(enable_s), .write_sig(write_sig_s),
    .write_data(write_data_s), .write_addr(write_addr_s), .done_write_sig(done_s),
    .pix_we(pix_we_s), .pix_x(pix_x_s), .pix_y(pix_y_s), .pix_color(pix_color_s_unused),
    .pix_ready(pix_ready_s), .row_done(row_done_s_unused), .busy(busy_s_unused)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] c;
  } pix_t;

  typedef struct packed {
    int         row;
    int         idx;
    logic [9:0] x;
    logic [7:0] color;
  } probe_t;

  int         checks = 0;
  int         errors = 0;
  pix_t       acc_q[$];
  probe_t     probes [12];
  logic [7:0] node_col [64];
  bit         skip [64];
  int         per_node = 4;
  int         done_after = -1;
  bit         hold_done = 1'b0;
  int         ready_mode = 0;
  int         y_model = 0;
  int         ws_cnt = 0;
  int         row_done_cnt = 0;
  int         prod_cnt = 0;
  int         p_idx;
  logic [31:0] p_rnd;
  bit         stall_q = 1'b0;
  logic [28:0] prev_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_50);
    #2;
  endtask

  // Producer: holds each node for per_node cycles while write_sig is high.
  always @(negedge clk_50) begin
    if (write_sig !== 1'b1) begin
      prod_cnt       = 0;
      write_addr     = 8'hFF;
      write_data     = 32'h0;
      done_write_sig = hold_done;
    end else begin
      p_idx = prod_cnt / per_node;
      if (p_idx > 63) p_idx = 63;
      write_addr     = skip[p_idx] ? 8'hFF : 8'(p_idx);
      p_rnd          = $urandom();
      write_data     = {p_rnd[31:8], node_col[p_idx]};
      done_write_sig = hold_done || (done_after >= 0 && prod_cnt >= done_after);
      prod_cnt++;
    end
  end

  // Ready driver and output monitor share one block so the sampled ready is the one in force.
  always @(negedge clk_50) begin
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = (pix_ready === 1'b1) ? 1'b0 : 1'b1;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset === 1'b0) begin
      if (stall_q) chk("stall_hold", 32'({pix_we, pix_x, pix_y, pix_color}), 32'(prev_out));
      stall_q  = pix_we && !pix_ready;
      prev_out = {pix_we, pix_x, pix_y, pix_color};
      if (pix_we && pix_ready) acc_q.push_back('{x: pix_x, y: pix_y, c: pix_color});
      if (row_done) row_done_cnt++;
      if (write_sig) ws_cnt++;
    end else begin
      stall_q = 1'b0;
    end
  end

  // Small instance: done follows write_sig, so every capture ends on a fresh edge.
  always @(negedge clk_50) begin
    done_s = write_sig_s;
    if (reset_s === 1'b0 && !s_done && pix_we_s && pix_x_s == 10'd0) begin
      rows_s++;
      chk((rows_s == 480) ? "y_row480" : (rows_s == 481) ? "y_row481" : "y_row",
          32'(pix_y_s), 32'((rows_s - 1) % 480));
      if (rows_s == 481) s_done = 1'b1;
    end
  end

  function automatic pix_t expect_pix(input int i);
    int n;
    bit written;
    n = i / 4;
    written = !skip[n] && (done_after < 0 || n * per_node <= done_after);
    return '{x: 10'(i), y: 10'(y_model), c: written ? node_col[n] : 8'h00};
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, " write_sig"}, 32'(write_sig), 0);
    chk({tag, " pix_we"}, 32'(pix_we), 0);
    chk({tag, " pix_x"}, 32'(pix_x), 0);
    chk({tag, " pix_y"}, 32'(pix_y), 0);
    chk({tag, " pix_color"}, 32'(pix_color), 0);
    chk({tag, " row_done"}, 32'(row_done), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  task automatic run_row(input string name, input int row_id);
    int base, wsb, rdb, n, mism, first_bad, rule_c, exp_c;
    base = acc_q.size();
    wsb  = ws_cnt;
    rdb  = row_done_cnt;
    enable = 1'b1;
    tick();
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    chk({name, " start"}, 32'(busy), 1);
    enable = 1'b0;
    n = 0;
    while (row_done_cnt == rdb && n < 3000) begin tick(); n++; end
    tick();
    chk({name, " pix_count"}, 32'(acc_q.size() - base), 256);
    mism = 0;
    first_bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (base + i >= acc_q.size() || acc_q[base + i] !== expect_pix(i)) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk($sformatf("%s pixels (first bad %0d)", name, first_bad), 32'(mism), 0);
    rule_c = 63 * per_node + 1;
    exp_c  = (done_after >= 0 && done_after < rule_c) ? done_after : rule_c;
    chk({name, " capture_len"}, 32'(ws_cnt - wsb), 32'(exp_c + 1));
    chk({name, " row_done"}, 32'(row_done_cnt - rdb), 1);
    chk({name, " idle_after"}, 32'(busy), 0);
    for (int p = 0; p < 12; p++) begin
      if (probes[p].row == row_id) begin
        if (base + probes[p].idx < acc_q.size()) begin
          chk($sformatf("%s x@%0d", name, probes[p].idx),
              32'(acc_q[base + probes[p].idx].x), 32'(probes[p].x));
          chk($sformatf("%s color@%0d", name, probes[p].idx),
              32'(acc_q[base + probes[p].idx].c), 32'(probes[p].color));
        end else begin
          chk($sformatf("%s probe present %0d", name, probes[p].idx), 0, 1);
        end
      end
    end
    y_model = (y_model + 1) % 480;
  endtask

  task automatic set_alternating();
    for (int n = 0; n < 64; n++) begin
      node_col[n] = (n % 2 == 0) ? 8'hE0 : 8'hFF;
      skip[n] = 1'b0;
    end
    per_node   = 4;
    done_after = -1;
    hold_done  = 1'b0;
    ready_mode = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, rdb, n;
    reset   = 1'b1;
    reset_s = 1'b1;
    enable  = 1'b0;
    s_go    = 1'b0;
    s_done  = 1'b0;
    set_alternating();

    probes[0]  = '{row: 1, idx: 0,   x: 10'd0,   color: 8'hE0};
    probes[1]  = '{row: 1, idx: 3,   x: 10'd3,   color: 8'hE0};
    probes[2]  = '{row: 1, idx: 4,   x: 10'd4,   color: 8'hFF};
    probes[3]  = '{row: 1, idx: 7,   x: 10'd7,   color: 8'hFF};
    probes[4]  = '{row: 1, idx: 255, x: 10'd255, color: 8'hFF};
    probes[5]  = '{row: 4, idx: 39,  x: 10'd39,  color: 8'hFF};
    probes[6]  = '{row: 4, idx: 40,  x: 10'd40,  color: 8'h00};
    probes[7]  = '{row: 4, idx: 43,  x: 10'd43,  color: 8'h00};
    probes[8]  = '{row: 4, idx: 44,  x: 10'd44,  color: 8'hFF};
    probes[9]  = '{row: 5, idx: 0,   x: 10'd0,   color: 8'hE0};
    probes[10] = '{row: 5, idx: 4,   x: 10'd4,   color: 8'hFF};
    probes[11] = '{row: 5, idx: 255, x: 10'd255, color: 8'hFF};

    tick();
    tick();
    check_reset_state("por");
    reset   = 1'b0;
    reset_s = 1'b0;
    tick();
    s_go = 1'b1;

    run_row("b1", 1);

    ready_mode = 1;
    run_row("b2_toggle", 2);
    ready_mode = 0;

    skip[10] = 1'b1;
    run_row("b4_skip", 4);
    skip[10] = 1'b0;

    hold_done = 1'b1;
    tick();
    run_row("b5_done_held", 5);
    hold_done = 1'b0;
    tick();

    per_node   = 1;
    done_after = 32;
    run_row("early_done", 0);

    done_after = 64;
    run_row("done_and_last", 0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 64; k++) begin
        node_col[k] = 8'($urandom_range(0, 255));
        skip[k]     = (k < 63) && ($urandom_range(0, 9) == 0);
      end
      per_node   = $urandom_range(1, 4);
      done_after = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 300) : -1;
      ready_mode = 2;
      run_row($sformatf("rand%0d", r), 0);
    end

    set_alternating();
    base = acc_q.size();
    rdb  = row_done_cnt;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n = 0;
    while (acc_q.size() - base < 100 && n < 2000) begin tick(); n++; end
    chk("b6 reached pixel 100", 32'(acc_q.size() - base), 100);
    reset = 1'b1;
    #1;
    check_reset_state("b6");
    tick();
    tick();
    tick();
    chk("b6 no more pixels", 32'(acc_q.size() - base), 100);
    chk("b6 no row_done", 32'(row_done_cnt - rdb), 0);
    reset = 1'b0;
    y_model = 0;
    tick();
    base = acc_q.size();
    run_row("b6_next", 1);
    if (base < acc_q.size()) chk("b6 next row y", 32'(acc_q[base].y), 0);
    else chk("b6 next row present", 0, 1);

    n = 0;
    while (!s_done && n < 20000) begin tick(); n++; end
    chk("wrap rows finished", 32'(s_done), 1);
    chk("wrap row count", 32'(rows_s), 481);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_row_receiver.md
GRID_ROW_RECEIVER -- requirements
Module: grid_row_receiver

Interface
REQ-001 Parameter NODES, default 64: nodes per row; the legal capture address range is 0..NODES-1.
REQ-002 Parameter CELL_W, default 4: screen pixels drawn per node, horizontally.
REQ-003 Parameter SCREEN_H, default 480: number of pixel rows before the Y pointer wraps.
REQ-004 clk_50  input  1  single system clock; all logic runs on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  permits a new row request while high.
REQ-007 write_sig  output  1  request to the grid producer; held high for the whole capture.
REQ-008 write_data  input  32  node colour from the producer; only bits [7:0] are used (RGB332).
REQ-009 write_addr  input  8  node index for write_data.
REQ-010 done_write_sig  input  1  producer end-of-row flag; level signal that may stay high.
REQ-011 pix_we  output  1  pixel write strobe to the VGA frame-buffer writer.
REQ-012 pix_x  output  10  pixel column.
REQ-013 pix_y  output  10  pixel row.
REQ-014 pix_color  output  8  RGB332 pixel colour.
REQ-015 pix_ready  input  1  the frame-buffer writer accepts the pixel when pix_we and pix_ready are both high.
REQ-016 row_done  output  1  one-cycle pulse when a row has been fully drawn.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, CAPTURE, SETTLE, DRAIN and ADVANCE.
REQ-019 IDLE: when enable=1, go to CAPTURE and assert write_sig on the next cycle.
REQ-020 CAPTURE: every cycle with write_addr<NODES, store write_data[7:0] into buffer[write_addr] and set valid[write_addr]; ignore addresses >=NODES.
REQ-021 CAPTURE exit: go to SETTLE on the first of these two events: (a) a rising edge of done_write_sig, detected against a registered copy; (b) write_addr==NODES-1 captured on 2 consecutive cycles.
REQ-022 SETTLE: deassert write_sig for 1 cycle, then go to DRAIN; write_sig SHALL be low in SETTLE, DRAIN and ADVANCE.
REQ-023 DRAIN: visit node n=0..NODES-1 and sub-column k=0..CELL_W-1, with k varying fastest. For each, present pix_x=n*CELL_W+k, pix_y=y_ptr and pix_color=buffer[n]; if valid[n]=0, present 8'h00 instead of buffer[n].
REQ-024 Handshake: pix_we, pix_x, pix_y and pix_color SHALL stay stable until accepted; the next pixel is presented on the cycle after acceptance.
REQ-025 Throughput: with pix_ready tied high, DRAIN SHALL take exactly NODES*CELL_W cycles (256 at defaults).
REQ-026 ADVANCE: pulse row_done, clear all valid bits, and update y_ptr to (y_ptr==SCREEN_H-1) ? 0 : y_ptr+1; then go to CAPTURE if enable=1, otherwise IDLE.
REQ-027 If enable falls during CAPTURE, SETTLE or DRAIN, the current row SHALL still complete; the new enable value is sampled only in ADVANCE.
REQ-028 done_write_sig high on entry to CAPTURE, without a rising edge, SHALL NOT end the capture.
REQ-029 If done_write_sig rises and the second NODES-1 cycle occur together, the FSM SHALL make a single transition to SETTLE.

Reset
REQ-030 On reset assertion the block SHALL go to IDLE and drive write_sig=0, pix_we=0, pix_x=0, pix_y=0, pix_color=0, row_done=0, busy=0, with y_ptr=0, all valid bits 0 and the done-edge register 0.
REQ-031 Reset asserted mid-row SHALL abandon the row immediately, with no further pix_we, and SHALL NOT pulse row_done.
REQ-032 Buffer contents need not be reset; the valid bits alone gate their use.

Structure
REQ-033 Shared package heatmap_pkg SHALL hold NODES, CELL_W, SCREEN_H, the FSM state encoding and the RGB332 colour constants (RED, ORANGE, MARIGOLD, WHITE, CYAN, PINK, PURPLE, BLACK).
REQ-034 The 64x8 storage SHALL be one sub-module, row_buffer: one write port plus one registered read port of 1-cycle latency, which DRAIN prefetches.

Verification
REQ-035 Bench 1: a producer model runs the 4-cycle-per-node protocol with node colours 8'hE0/8'hFF alternating -> 256 pixels, pix_x 0..255, pix_y=0; pixels 0-3 are E0, 4-7 are FF; one row_done pulse.
REQ-036 Bench 2: pix_ready toggles 1,0,1,0 during DRAIN -> no pixel is lost or duplicated, all outputs are stable while ready=0, and 256 acceptances occur.
REQ-037 Bench 3: 481 consecutive rows -> pix_y of row 480 is 479 and of row 481 is 0.
REQ-038 Bench 4: the producer skips address 10 -> the pixels for x=40..43 are 8'h00.
REQ-039 Bench 5: done_write_sig held high from time 0 -> capture ends only by the NODES-1 rule; the result matches bench 1.
REQ-040 Bench 6: reset pulse at DRAIN pixel 100 -> pix_we=0 and busy=0 in the same cycle, no row_done, and the next row starts with pix_y=0.
